// File: rtl/myproject_div_pkg.sv
// Shared widths, saturation limits and FSM encoding for the sequential signed divider.
// The helpers return the unsigned magnitude of two's-complement operands.
package myproject_div_pkg;

   localparam int DIN0_W = 32;
   localparam int DIN1_W = 18;
   localparam int DOUT_W = 14;
   localparam int REM_W  = 19;
   localparam int ITER   = 32;
   localparam int CNT_W  = 6;

   localparam int Q_MAX = 8191;
   localparam int Q_MIN = -8192;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // The most negative input maps to 2^(W-1), which still fits the unsigned result.
   function automatic logic [DIN0_W-1:0] abs_dividend(input logic [DIN0_W-1:0] v);
      abs_dividend = v[DIN0_W-1] ? (~v + DIN0_W'(1)) : v;
   endfunction

   function automatic logic [DIN1_W-1:0] abs_divisor(input logic [DIN1_W-1:0] v);
      abs_divisor = v[DIN1_W-1] ? (~v + DIN1_W'(1)) : v;
   endfunction

endpackage

// File: rtl/myproject_sdiv_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor magnitude whenever the shifted remainder covers it.
module myproject_sdiv_step
   import myproject_div_pkg::*;
(
   input  logic [REM_W-1:0]  rem,
   input  logic              bit_in,
   input  logic [DIN1_W-1:0] divisor_mag,
   output logic [REM_W-1:0]  rem_next,
   output logic              q_bit
);

   logic [REM_W:0] w_shift;
   logic [REM_W:0] w_dvs;
   logic [REM_W:0] w_sub;

   // One guard bit keeps the compare exact for any remainder value.
   assign w_shift  = {rem, bit_in};
   assign w_dvs    = {{(REM_W + 1 - DIN1_W){1'b0}}, divisor_mag};
   assign q_bit    = (w_shift >= w_dvs);
   assign w_sub    = q_bit ? w_dvs : '0;
   assign rem_next = REM_W'(w_shift - w_sub);

endmodule

// File: rtl/myproject_sdiv_32s_18s_14_seq.sv
// Sequential signed divider 32s / 18s -> 14s quotient (saturated) + 18s remainder,
// one restoring step per cycle, driven by an ap_start/ap_done handshake.
module myproject_sdiv_32s_18s_14_seq
   import myproject_div_pkg::*;
#(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 32,
   parameter int din1_WIDTH = 18,
   parameter int dout_WIDTH = 14
)
(
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ap_start,
   output logic                  ap_idle,
   output logic                  ap_done,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout_q,
   output logic [din1_WIDTH-1:0] dout_r,
   output logic                  dout_ovf,
   output logic                  dout_dbz,
   output state_t                o_dbg_state
);

   if (din0_WIDTH != DIN0_W || din1_WIDTH != DIN1_W || dout_WIDTH != DOUT_W || ID < 0) begin : g_param_check
      $error("myproject_sdiv_32s_18s_14_seq: widths are fixed at 32/18/14");
   end

   // Handshake: ap_start is taken only while ap_idle is high (one-cycle accept);
   // ap_done is a single-cycle pulse, and dout_* stay valid from then until the
   // next accepted start clears them. Starts outside IDLE are dropped, not queued.

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DIN0_W-1:0]   r_dvd;
   logic [DIN0_W-1:0]   r_quo;
   logic [REM_W-1:0]    r_rem;
   logic [DIN1_W-1:0]   r_dmag;
   logic                r_sgn0;
   logic                r_sgn1;
   logic [DOUT_W-1:0]   r_q;
   logic [DIN1_W-1:0]   r_r;
   logic                r_ovf;
   logic                r_dbz;
   logic                r_done;

   logic [REM_W-1:0]    w_rem_next;
   logic                w_q_bit;
   logic                w_q_neg;
   logic                w_pos_ovf;
   logic                w_neg_ovf;
   logic [DOUT_W-1:0]   w_q_signed;
   logic [DIN1_W-1:0]   w_r_signed;

   myproject_sdiv_step u_step (
      .rem         (r_rem),
      .bit_in      (r_dvd[DIN0_W-1]),
      .divisor_mag (r_dmag),
      .rem_next    (w_rem_next),
      .q_bit       (w_q_bit)
   );

   assign w_q_neg    = r_sgn0 ^ r_sgn1;
   assign w_pos_ovf  = !w_q_neg && (r_quo > DIN0_W'(Q_MAX));
   assign w_neg_ovf  = w_q_neg && (r_quo > DIN0_W'(-Q_MIN));
   assign w_q_signed = w_q_neg ? (~r_quo[DOUT_W-1:0] + DOUT_W'(1)) : r_quo[DOUT_W-1:0];
   // Remainder magnitude is below |divisor| <= 2^17, so the low 18 bits hold it exactly.
   assign w_r_signed = r_sgn0 ? (~r_rem[DIN1_W-1:0] + DIN1_W'(1)) : r_rem[DIN1_W-1:0];

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_dvd   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_dmag  <= '0;
         r_sgn0  <= 1'b0;
         r_sgn1  <= 1'b0;
         r_q     <= '0;
         r_r     <= '0;
         r_ovf   <= 1'b0;
         r_dbz   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (ap_start) begin
                  r_dvd   <= abs_dividend(din0);
                  r_dmag  <= abs_divisor(din1);
                  r_sgn0  <= din0[DIN0_W-1];
                  r_sgn1  <= din1[DIN1_W-1];
                  r_rem   <= '0;
                  r_quo   <= '0;
                  r_cnt   <= '0;
                  r_q     <= '0;
                  r_r     <= '0;
                  r_ovf   <= 1'b0;
                  r_dbz   <= 1'b0;
                  r_state <= (din1 == '0) ? ST_FIX : ST_CALC;
               end
            end
            ST_CALC: begin
               r_rem <= w_rem_next;
               r_dvd <= {r_dvd[DIN0_W-2:0], 1'b0};
               r_quo <= {r_quo[DIN0_W-2:0], w_q_bit};
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(ITER - 1)) begin
                  r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (r_dmag == '0) begin
                  r_q   <= r_sgn0 ? DOUT_W'(Q_MIN) : DOUT_W'(Q_MAX);
                  r_r   <= '0;
                  r_dbz <= 1'b1;
                  r_ovf <= 1'b0;
               end else begin
                  r_r   <= w_r_signed;
                  r_ovf <= w_pos_ovf | w_neg_ovf;
                  if (w_pos_ovf) begin
                     r_q <= DOUT_W'(Q_MAX);
                  end else if (w_neg_ovf) begin
                     r_q <= DOUT_W'(Q_MIN);
                  end else begin
                     r_q <= w_q_signed;
                  end
               end
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ap_idle     = (r_state == ST_IDLE);
   assign ap_done     = r_done;
   assign dout_q      = r_q;
   assign dout_r      = r_r;
   assign dout_ovf    = r_ovf;
   assign dout_dbz    = r_dbz;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_myproject_sdiv_32s_18s_14_seq.sv
// Bench for the sequential signed divider: directed vector table, handshake corner
// sequences, and randomized operands against an integer-arithmetic reference.
module tb_myproject_sdiv_32s_18s_14_seq;
   import myproject_div_pkg::*;

   logic        ap_clk;
   logic        ap_rst;
   logic        ap_start;
   logic        ap_idle;
   logic        ap_done;
   logic [31:0] din0;
   logic [17:0] din1;
   logic [13:0] dout_q;
   logic [17:0] dout_r;
   logic        dout_ovf;
   logic        dout_dbz;
   state_t      dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [17:0] b;
      logic [13:0] q;
      logic [17:0] r;
      logic        ovf;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   myproject_sdiv_32s_18s_14_seq dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .ap_start    (ap_start),
      .ap_idle     (ap_idle),
      .ap_done     (ap_done),
      .din0        (din0),
      .din1        (din1),
      .dout_q      (dout_q),
      .dout_r      (dout_r),
      .dout_ovf    (dout_ovf),
      .dout_dbz    (dout_dbz),
      .o_dbg_state (dbg_state)
   );

   // clock / watchdog
   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: C-style truncating division on wide integers, then saturation.
   task automatic ref_div(input logic [31:0] a, input logic [17:0] b,
                          output logic [13:0] q, output logic [17:0] r,
                          output logic ovf, output logic dbz, output int lat);
      longint sa, sb, tq, tr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
         dbz = 1'b1;
         ovf = 1'b0;
         r   = '0;
         q   = (sa >= 0) ? 14'h1FFF : 14'h2000;
         lat = 2;
      end else begin
         tq  = sa / sb;
         tr  = sa % sb;
         dbz = 1'b0;
         lat = 34;
         if (tq > 8191) begin
            q = 14'h1FFF; ovf = 1'b1;
         end else if (tq < -8192) begin
            q = 14'h2000; ovf = 1'b1;
         end else begin
            q = tq[13:0]; ovf = 1'b0;
         end
         r = tr[17:0];
      end
   endtask

   task automatic add_vec(input logic [31:0] a, input logic [17:0] b, input logic [13:0] q,
                          input logic [17:0] r, input logic ovf, input logic dbz, input int lat);
      vec_t v;
      v.a = a; v.b = b; v.q = q; v.r = r; v.ovf = ovf; v.dbz = dbz; v.lat = lat;
      vecs.push_back(v);
   endtask

   task automatic count_done(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         @(negedge ap_clk);
         if (ap_done) cnt++;
      end
   endtask

   // driver: start one op, scramble operands after capture, time ap_done, check results
   task automatic do_op(input string tag, input logic [31:0] a, input logic [17:0] b,
                        input logic [13:0] eq, input logic [17:0] er,
                        input logic eovf, input logic edbz, input int elat);
      int  k;
      bit  seen;
      @(negedge ap_clk);
      ap_start = 1'b1; din0 = a; din1 = b;
      @(posedge ap_clk);
      #1;
      ap_start = 1'b0;
      din0 = $urandom;
      din1 = 18'($urandom);
      k = 1;
      seen = 0;
      @(negedge ap_clk);
      check({tag, ".idle_low"}, 64'(ap_idle), 64'(0));
      check({tag, ".cleared"}, 64'({dout_q, dout_r, dout_ovf, dout_dbz}), 64'(0));
      while (k < 120) begin
         if (ap_done) begin
            seen = 1;
            break;
         end
         @(posedge ap_clk);
         k++;
         @(negedge ap_clk);
      end
      check({tag, ".done_seen"}, 64'(seen), 64'(1));
      check({tag, ".latency"}, 64'(k), 64'(elat));
      check({tag, ".q"}, 64'(dout_q), 64'(eq));
      check({tag, ".r"}, 64'(dout_r), 64'(er));
      check({tag, ".ovf"}, 64'(dout_ovf), 64'(eovf));
      check({tag, ".dbz"}, 64'(dout_dbz), 64'(edbz));
      @(negedge ap_clk);
      check({tag, ".done_pulse"}, 64'(ap_done), 64'(0));
      check({tag, ".idle_back"}, 64'(ap_idle), 64'(1));
      check({tag, ".q_hold"}, 64'(dout_q), 64'(eq));
   endtask

   initial begin
      logic [31:0] a;
      logic [17:0] b;
      logic [13:0] q;
      logic [17:0] r;
      logic        ovf, dbz;
      int          lat, cnt, k;

      ap_rst = 1'b1; ap_start = 1'b0; din0 = '0; din1 = '0;
      repeat (3) @(posedge ap_clk);
      #1 ap_rst = 1'b0;
      @(negedge ap_clk);
      check("reset.idle", 64'(ap_idle), 64'(1));
      check("reset.done", 64'(ap_done), 64'(0));
      check("reset.outs", 64'({dout_q, dout_r, dout_ovf, dout_dbz}), 64'(0));
      check("reset.state", 64'(dbg_state), 64'(ST_IDLE));

      // directed vectors
      add_vec(32'd1000,         18'd7,        14'd142,       18'd6,        1'b0, 1'b0, 34);
      add_vec(-32'sd1000,       18'd7,        -14'sd142,     -18'sd6,      1'b0, 1'b0, 34);
      add_vec(32'd1000,         -18'sd7,      -14'sd142,     18'd6,        1'b0, 1'b0, 34);
      add_vec(32'd100000,       18'd3,        14'h1FFF,      18'd1,        1'b1, 1'b0, 34);
      add_vec(32'h8000_0000,    18'h20000,    14'h1FFF,      18'd0,        1'b1, 1'b0, 34);
      add_vec(-32'sd5,          18'd0,        14'h2000,      18'd0,        1'b0, 1'b1, 2);
      add_vec(32'd5,            18'd0,        14'h1FFF,      18'd0,        1'b0, 1'b1, 2);
      add_vec(32'd0,            18'd0,        14'h1FFF,      18'd0,        1'b0, 1'b1, 2);
      add_vec(32'd8191,         18'd1,        14'h1FFF,      18'd0,        1'b0, 1'b0, 34);
      add_vec(32'd8192,         18'd1,        14'h1FFF,      18'd0,        1'b1, 1'b0, 34);
      add_vec(-32'sd8192,       18'd1,        14'h2000,      18'd0,        1'b0, 1'b0, 34);
      add_vec(-32'sd8193,       18'd1,        14'h2000,      18'd0,        1'b1, 1'b0, 34);
      add_vec(32'd7,            18'd1000,     14'd0,         18'd7,        1'b0, 1'b0, 34);
      add_vec(-32'sd7,          18'd1000,     14'd0,         -18'sd7,      1'b0, 1'b0, 34);
      add_vec(32'h7FFF_FFFF,    18'd131071,   14'h1FFF,      18'd16383,    1'b1, 1'b0, 34);
      add_vec(32'h8000_0000,    18'd1,        14'h2000,      18'd0,        1'b1, 1'b0, 34);
      add_vec(-32'sd100,        -18'sd7,      14'd14,        -18'sd2,      1'b0, 1'b0, 34);
      for (int i = 0; i < vecs.size(); i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
               vecs[i].ovf, vecs[i].dbz, vecs[i].lat);
      end

      // ignored start mid-CALC, then reset abort, then a clean op
      @(negedge ap_clk);
      ap_start = 1'b1; din0 = 32'd1000; din1 = 18'd7;
      @(posedge ap_clk);
      #1 ap_start = 1'b0;
      k = 1;
      while (k < 5) begin
         @(posedge ap_clk);
         k++;
      end
      @(negedge ap_clk);
      ap_start = 1'b1; din0 = -32'sd5; din1 = 18'd0;
      @(posedge ap_clk);
      #1 ap_start = 1'b0;
      k++;
      while (k < 10) begin
         @(posedge ap_clk);
         k++;
      end
      @(negedge ap_clk);
      check("abort.busy_before_rst", 64'(ap_idle), 64'(0));
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1 ap_rst = 1'b0;
      @(negedge ap_clk);
      check("abort.idle", 64'(ap_idle), 64'(1));
      check("abort.outs", 64'({dout_q, dout_r, dout_ovf, dout_dbz}), 64'(0));
      count_done(45, cnt);
      check("abort.no_done", 64'(cnt), 64'(0));
      do_op("after_abort", 32'd1000, 18'd7, 14'd142, 18'd6, 1'b0, 1'b0, 34);

      // start pulsed at cycle 5 without reset: only the first op completes
      @(negedge ap_clk);
      ap_start = 1'b1; din0 = 32'd1000; din1 = 18'd7;
      @(posedge ap_clk);
      #1 ap_start = 1'b0;
      repeat (4) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_start = 1'b1; din0 = 32'd7; din1 = 18'd1;
      @(posedge ap_clk);
      #1 ap_start = 1'b0;
      cnt = 0;
      k = 0;
      repeat (70) begin
         @(negedge ap_clk);
         if (ap_done) begin
            cnt++;
            check("ignored_start.q", 64'(dout_q), 64'(14'd142));
         end
      end
      check("ignored_start.one_done", 64'(cnt), 64'(1));

      // reset and start in the same cycle: start is dropped
      @(negedge ap_clk);
      ap_rst = 1'b1; ap_start = 1'b1; din0 = 32'd1000; din1 = 18'd7;
      @(posedge ap_clk);
      #1 ap_rst = 1'b0; ap_start = 1'b0;
      @(negedge ap_clk);
      check("rst_start.idle", 64'(ap_idle), 64'(1));
      count_done(45, cnt);
      check("rst_start.no_done", 64'(cnt), 64'(0));

      // start asserted during the DONE cycle is ignored
      @(negedge ap_clk);
      ap_start = 1'b1; din0 = 32'd100; din1 = 18'd10;
      @(posedge ap_clk);
      #1 ap_start = 1'b0;
      k = 0;
      do begin
         @(negedge ap_clk);
         k++;
      end while (!ap_done && k < 100);
      check("done_start.done_seen", 64'(ap_done), 64'(1));
      ap_start = 1'b1; din0 = 32'd50; din1 = 18'd5;
      @(posedge ap_clk);
      #1 ap_start = 1'b0;
      @(negedge ap_clk);
      check("done_start.idle", 64'(ap_idle), 64'(1));
      count_done(45, cnt);
      check("done_start.no_done", 64'(cnt), 64'(0));
      check("done_start.q_hold", 64'(dout_q), 64'(14'd10));

      // randomized operands against the reference
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0: a = $urandom;
            1: a = 32'($urandom_range(0, 200000));
            2: a = -32'($urandom_range(0, 200000));
            default: a = 32'($urandom_range(0, 2000));
         endcase
         case ($urandom_range(0, 7))
            0: b = '0;
            1, 2: b = 18'($urandom_range(1, 40));
            3: b = -18'($urandom_range(1, 40));
            default: b = 18'($urandom);
         endcase
         ref_div(a, b, q, r, ovf, dbz, lat);
         do_op($sformatf("rnd%0d", i), a, b, q, r, ovf, dbz, lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
